// File: rtl/axi4stream_fifo_if.sv
// AXI4-Stream beat bundle shared by the FIFO write (slave) and read (master) sides.
interface axi4stream_fifo_if #(
  parameter int unsigned N = 1,
  parameter int unsigned I = 1,
  parameter int unsigned D = 1,
  parameter int unsigned U = 1
);
  logic           tvalid;
  logic           tready;
  logic [8*N-1:0] tdata;
  logic [N-1:0]   tstrb;
  logic [N-1:0]   tkeep;
  logic           tlast;
  logic [I-1:0]   tid;
  logic [D-1:0]   tdest;
  logic [U-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4stream_fifo.sv
// First-word fall-through AXI4-Stream FIFO with registered tready.
// Define AXI4STREAM_FIFO_PACKET_EN to hold tvalid until a whole packet (or a full FIFO) is stored.
module axi4stream_fifo #(
  parameter int unsigned N     = 1,
  parameter int unsigned I     = 1,
  parameter int unsigned D     = 1,
  parameter int unsigned U     = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi4stream_fifo_if.slave        s,
  axi4stream_fifo_if.master       m,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("axi4stream_fifo: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [8*N-1:0] data;
    logic [N-1:0]   strb;
    logic [N-1:0]   keep;
    logic           last;
    logic [I-1:0]   id;
    logic [D-1:0]   dest;
    logic [U-1:0]   user;
  } beat_t;

  beat_t             mem [DEPTH];
  beat_t             wr_beat;
  beat_t             rd_beat;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW-1:0]   level_next;
  logic              s_ready_q, s_ready_d;
  logic              empty, full;
  logic              wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign level = wptr_q - rptr_q;

  assign wr_en = s.tvalid && s_ready_q;
  assign rd_en = m.tvalid && m.tready;

  assign wr_beat = '{data: s.tdata, strb: s.tstrb, keep: s.tkeep, last: s.tlast,
                     id: s.tid, dest: s.tdest, user: s.tuser};
  assign rd_beat = mem[rptr_q[AddrW-1:0]];

  assign s.tready = s_ready_q;
  assign m.tdata  = rd_beat.data;
  assign m.tstrb  = rd_beat.strb;
  assign m.tkeep  = rd_beat.keep;
  assign m.tlast  = rd_beat.last;
  assign m.tid    = rd_beat.id;
  assign m.tdest  = rd_beat.dest;
  assign m.tuser  = rd_beat.user;

  always_comb begin
    wptr_d     = wr_en ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d     = rd_en ? rptr_q + PtrW'(1) : rptr_q;
    level_next = level;
    case ({wr_en, rd_en})
      2'b10:   level_next = level + PtrW'(1);
      2'b01:   level_next = level - PtrW'(1);
      default: level_next = level;
    endcase
    // tready looks at the post-edge level, so a same-cycle read never frees a full slot
    s_ready_d = (level_next < PtrW'(DEPTH));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wptr_q[AddrW-1:0]] <= wr_beat;
    end
  end

`ifdef AXI4STREAM_FIFO_PACKET_EN
  logic [PtrW-1:0] pkt_q, pkt_d;

  always_comb begin
    pkt_d = pkt_q;
    case ({wr_en && s.tlast, rd_en && m.tlast})
      2'b10:   pkt_d = pkt_q + PtrW'(1);
      2'b01:   pkt_d = pkt_q - PtrW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  // A full FIFO releases data even without tlast so oversize packets cannot deadlock
  assign m.tvalid = !empty && ((pkt_q != '0) || full);
`else
  assign m.tvalid = !empty;
`endif
endmodule

// File: doc/axi4stream_fifo.md
AXI4STREAM_FIFO -- requirements
Module: axi4stream_fifo

Interface
REQ-001 The block SHALL have one clock, ACLK, and one reset, ARESETn; ARESETn is synchronous and active-low.
REQ-002 Parameter N, default 1: TDATA width in bytes; TSTRB/TKEEP width.
REQ-003 Parameter I, default 1: TID width in bits.
REQ-004 Parameter D, default 1: TDEST width in bits.
REQ-005 Parameter U, default 1: TUSER width in bits.
REQ-006 Parameter DEPTH, default 16: number of beats stored; a power of 2, >=2; other values SHALL be rejected at elaboration.
REQ-007 ACLK  input  1  clock; all state changes on the rising edge.
REQ-008 ARESETn  input  1  synchronous active-low reset.
REQ-009 S_TVALID  input  1  upstream beat valid.
REQ-010 S_TREADY  output  1  FIFO can accept a beat.
REQ-011 S_TDATA  input  8*N  upstream data.
REQ-012 S_TSTRB, S_TKEEP  input  N each  upstream byte qualifiers.
REQ-013 S_TLAST, S_TID, S_TDEST, S_TUSER  input  1/I/D/U  upstream packet sideband.
REQ-014 M_TVALID  output  1  downstream beat valid.
REQ-015 M_TREADY  input  1  downstream accepts beat.
REQ-016 M_TDATA, M_TSTRB, M_TKEEP  output  8*N/N/N  downstream data and byte qualifiers.
REQ-017 M_TLAST, M_TID, M_TDEST, M_TUSER  output  1/I/D/U  downstream packet sideband.
REQ-018 LEVEL  output  $clog2(DEPTH)+1  beats currently stored, 0..DEPTH.

Function
REQ-019 Each entry SHALL store the full beat (TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER); order SHALL be preserved, with no loss and no duplication.
REQ-020 Write: S_TVALID&&S_TREADY at a rising edge stores one beat. Read: M_TVALID&&M_TREADY at a rising edge removes one beat.
REQ-021 S_TREADY SHALL be a registered output: S_TREADY = (LEVEL<DEPTH). It is low when full, even if a read occurs in the same cycle (no full-bypass).
REQ-022 First-word fall-through: a beat written at edge k SHALL appear on M_* with M_TVALID high after edge k; there is no empty-bypass.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Empty: pointers equal. Full: MSBs differ and the remaining bits are equal.
REQ-024 LEVEL SHALL change as follows: +1 on write-only, -1 on read-only, unchanged on simultaneous read and write or on neither.
REQ-025 While M_TVALID=1 and M_TREADY=0, M_TVALID SHALL stay high and all M_* payload SHALL stay stable.
REQ-026 M_* payload SHALL be undefined while M_TVALID=0. M_TVALID SHALL NOT depend combinationally on M_TREADY.
REQ-027 Throughput SHALL be one beat per cycle sustained when 0<LEVEL<DEPTH and both sides handshake.

Reset
REQ-028 While ARESETn=0 at a rising edge: pointers, LEVEL and the packet counter SHALL clear to 0; S_TREADY=0 and M_TVALID=0 during reset; storage array is not reset.
REQ-029 Reset mid-operation SHALL discard all stored beats. S_TREADY=1 from the first edge after ARESETn returns high.

Configuration
REQ-030 Macro AXI4STREAM_FIFO_PACKET_EN, when defined, enables packet mode. A packet counter of $clog2(DEPTH)+1 bits counts +1 per written beat with TLAST=1 and -1 per read beat with TLAST=1, unchanged when both occur together. M_TVALID = !empty && (pktcnt!=0 || full). The full term is the deadlock release for packets longer than DEPTH.
REQ-031 Without AXI4STREAM_FIFO_PACKET_EN, no packet counter exists, M_TVALID = !empty, and TLAST is stored as ordinary payload.

Verification (N=4, DEPTH=4)
REQ-032 Write 0x11111111 with M_TREADY=0 -> M_TVALID=1 and M_TDATA=0x11111111 one edge later; LEVEL=1.
REQ-033 Write 5 beats back-to-back with M_TREADY=0 -> 4 beats accepted, S_TREADY=0 after the 4th, LEVEL=4; with M_TREADY=1 -> beats out in order and the 5th accepted one cycle after the first read.
REQ-034 Continuous streaming of 64 beats with M_TREADY=1 -> one beat per cycle, LEVEL constant, pointers wrap cleanly, data matches the model.
REQ-035 Random M_TREADY stalls -> M_* stable while stalled; TID/TDEST/TUSER/TSTRB/TKEEP match input order.
REQ-036 Pull ARESETn low for one edge at LEVEL=3 -> LEVEL=0, M_TVALID=0, S_TREADY=1 on the next edge; old data never emitted.
REQ-037 PACKET_EN: write 3 beats with TLAST on the 3rd -> M_TVALID stays 0 until the 3rd is stored. Write 5 beats with no TLAST -> M_TVALID=1 once LEVEL=4.
